// File: rtl/des_pkg.sv
// DES permutation tables and mode encodings shared by the permutation pipeline.
// Table entry i (0-based) gives the 1-based DES input bit feeding DES output bit i+1.
// DES bit n (n = 1 is the MSB) maps to vector bit 64-n within a 64-bit lane.
package des_pkg;

  localparam logic [1:0] MODE_IP  = 2'b00;
  localparam logic [1:0] MODE_FP  = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TABLE [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

endpackage

// File: rtl/des_perm64.sv
// Single 64-bit lane DES permutation (IP, FP or pass-through), pure wiring plus a mux.
// Latency: combinational, zero cycles.
// Backpressure: none; the enclosing pipeline handles flow control.
module des_perm64
  import des_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  logic [63:0] ip_bits;
  logic [63:0] fp_bits;

  // Both permutations are fixed wiring generated from the package tables.
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign ip_bits[63-i] = din[64-IP_TABLE[i]];
    assign fp_bits[63-i] = din[64-FP_TABLE[i]];
  end

  // Select the permuted view; bypass and the reserved code both pass data through.
  always_comb begin
    dout = din;
    case (mode)
      MODE_IP: dout = ip_bits;
      MODE_FP: dout = fp_bits;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Multi-lane DES IP/FP/bypass unit with a PIPE_STAGES-deep register pipeline and a transfer counter.
// Latency: PIPE_STAGES cycles from input acceptance to out_valid.
// Backpressure: global stall; every stage holds while out_valid & ~out_ready, and in_ready follows.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [64*NUM_LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [64*NUM_LANES-1:0] out_data,
  output logic                    out_err,
  output logic [15:0]             xfer_count
);

  localparam int DW = 64 * NUM_LANES;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [DW-1:0]    dat;
  } stage_t;

  stage_t        stage_q [PIPE_STAGES];
  stage_t        stage_d [PIPE_STAGES];
  logic [DW-1:0] perm_dat;
  logic          advance;
  logic [15:0]   count_q;
  logic [15:0]   count_d;

  // One permutation instance per lane; lanes never mix bits.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    des_perm64 u_perm (
      .mode (in_mode),
      .din  (in_data[64*g +: 64]),
      .dout (perm_dat[64*g +: 64])
    );
  end

  // The whole pipe moves only when the output slot is empty or being drained.
  assign advance   = ~stage_q[PIPE_STAGES-1].vld | out_ready;
  assign in_ready  = advance;

  assign out_valid  = stage_q[PIPE_STAGES-1].vld;
  assign out_tag    = stage_q[PIPE_STAGES-1].tag;
  assign out_err    = stage_q[PIPE_STAGES-1].err;
  assign out_data   = stage_q[PIPE_STAGES-1].dat;
  assign xfer_count = count_q;

  // Next-state of the stage array: shift everything one slot on advance, else hold.
  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++) begin
      stage_d[s] = stage_q[s];
    end
    if (advance) begin
      stage_d[0].vld = in_valid;
      stage_d[0].tag = in_tag;
      stage_d[0].err = in_valid & (in_mode == MODE_RSV);
      stage_d[0].dat = perm_dat;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
  end

  // Completed-transfer counter that sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Stage registers and counter; reset drops any in-flight transactions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_q[s] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Self-checking bench for des_perm_pipe with four lanes and a three-stage pipe.
// Expected transactions are queued on acceptance and compared when the output handshakes.
// The reference permutation is computed from the arithmetic structure of the IP table.
module tb_des_perm_pipe;

  localparam int NL = 4;
  localparam int PS = 3;
  localparam int TW = 4;
  localparam int DW = 64 * NL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic [15:0]   xfer_count;

  typedef struct {
    logic [TW-1:0] tag;
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  des_perm_pipe #(.NUM_LANES(NL), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_data   (out_data),
    .out_err    (out_err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // IP: row r, column c of the table holds 58+2r-8c (rows 0..3) or 57+2(r-4)-8c (rows 4..7).
  function automatic logic [63:0] m_ip(input logic [63:0] x);
    logic [63:0] y;
    int r, c, src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      r = i / 8;
      c = i % 8;
      src = (r < 4) ? (58 + 2*r - 8*c) : (57 + 2*(r-4) - 8*c);
      y[63-i] = x[64-src];
    end
    return y;
  endfunction

  // FP is the inverse of IP: scatter each input bit back to the position IP took it from.
  function automatic logic [63:0] m_fp(input logic [63:0] x);
    logic [63:0] y;
    int r, c, src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      r = i / 8;
      c = i % 8;
      src = (r < 4) ? (58 + 2*r - 8*c) : (57 + 2*(r-4) - 8*c);
      y[64-src] = x[63-i];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] m_block(input logic [1:0] md, input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = x;
    for (int l = 0; l < NL; l++) begin
      if (md == 2'b00) y[64*l +: 64] = m_ip(x[64*l +: 64]);
      else if (md == 2'b01) y[64*l +: 64] = m_fp(x[64*l +: 64]);
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] rand_block();
    logic [DW-1:0] b;
    for (int l = 0; l < NL; l++) b[64*l +: 64] = {$urandom, $urandom};
    return b;
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] md, input logic [TW-1:0] tg, input logic [DW-1:0] x);
    exp_t e;
    e.tag = tg;
    e.err = (md == 2'b11);
    e.dat = m_block(md, x);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_tag = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL reset_xfer_count got %h want 0", xfer_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_known_vectors();
    logic [1:0]    md [5];
    logic [63:0]   l0 [5];
    logic [63:0]   want0 [5];
    logic [DW-1:0] blk [5];
    int            acc_cyc [5];
    exp_t          e;
    int            sent = 0, got = 0, cyc = 0;
    md    = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
    l0    = '{64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA, 64'h0000000000000001,
              64'hDEADBEEF01234567, 64'hFEDCBA9876543210};
    want0 = '{64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF, 64'h0000008000000000,
              64'hDEADBEEF01234567, 64'hFEDCBA9876543210};
    for (int i = 0; i < 5; i++) begin
      blk[i] = rand_block();
      blk[i][63:0] = l0[i];
    end
    while (got < 5 && cyc < 60) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 5);
      if (sent < 5) begin
        in_mode = md[sent]; in_tag = TW'(sent); in_data = blk[sent];
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL known_unexpected_output tag %h", out_tag);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (out_data !== e.dat || out_tag !== e.tag || out_err !== e.err) begin
            errors++;
            $display("FAIL known_txn tag %h err %b data %h want tag %h err %b data %h",
                     out_tag, out_err, out_data, e.tag, e.err, e.dat);
          end
          checks++;
          if (out_data[63:0] !== want0[got]) begin
            errors++; $display("FAIL known_lane0 got %h want %h", out_data[63:0], want0[got]);
          end
          checks++;
          if (cyc - acc_cyc[got] != PS) begin
            errors++; $display("FAIL latency got %0d want %0d", cyc - acc_cyc[got], PS);
          end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(mk_exp(in_mode, in_tag, in_data));
        acc_cyc[sent] = cyc;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 5) begin errors++; $display("FAIL known_timeout got %0d want 5", got); end
  endtask

  task automatic test_round_trip();
    logic [DW-1:0] orig [8];
    logic [DW-1:0] res [8];
    exp_t          e;
    int            sent, got, cyc;
    for (int i = 0; i < 8; i++) orig[i] = rand_block();
    for (int ph = 0; ph < 4; ph++) begin
      sent = 0; got = 0; cyc = 0;
      while (got < 8 && cyc < 80) begin
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = (sent < 8);
        if (sent < 8) begin
          in_tag = TW'(sent);
          case (ph)
            0: begin in_mode = 2'b00; in_data = orig[sent]; end
            1: begin in_mode = 2'b01; in_data = res[sent]; end
            2: begin in_mode = 2'b10; in_data = orig[sent]; end
            default: begin in_mode = 2'b11; in_data = orig[sent]; end
          endcase
        end
        #1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL rt_unexpected_output phase %0d", ph);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.dat || out_tag !== e.tag || out_err !== e.err) begin
              errors++;
              $display("FAIL rt_phase%0d tag %h err %b data %h want tag %h err %b data %h",
                       ph, out_tag, out_err, out_data, e.tag, e.err, e.dat);
            end
            if (ph == 0) res[got] = out_data;
            got++;
          end
        end
        if (in_valid && in_ready) begin
          e.tag = in_tag;
          e.err = (in_mode == 2'b11);
          e.dat = (ph == 0) ? m_block(2'b00, in_data) : orig[sent];
          exp_q.push_back(e);
          sent++;
        end
        cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got != 8) begin errors++; $display("FAIL rt_timeout phase %0d got %0d want 8", ph, got); end
    end
  endtask

  task automatic test_backpressure();
    exp_t          e;
    int            sent = 0, got = 0, cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [TW-1:0] prev_tag = '0;
    logic          prev_err = 1'b0;
    while (got < 16 && cyc < 600) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 45);
      in_valid  = (sent < 16) && ($urandom_range(0, 99) < 70);
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = TW'(sent);
      in_data   = rand_block();
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL bp_in_ready got %b out_valid %b out_ready %b", in_ready, out_valid, out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_dat || out_tag !== prev_tag || out_err !== prev_err) begin
          errors++;
          $display("FAIL bp_stable valid %b tag %h data %h want valid 1 tag %h data %h",
                   out_valid, out_tag, out_data, prev_tag, prev_dat);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat = out_data; prev_tag = out_tag; prev_err = out_err;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_duplicate tag %h", out_tag);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (out_data !== e.dat || out_tag !== e.tag || out_err !== e.err) begin
            errors++;
            $display("FAIL bp_txn tag %h err %b data %h want tag %h err %b data %h",
                     out_tag, out_err, out_data, e.tag, e.err, e.dat);
          end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(mk_exp(in_mode, in_tag, in_data));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 16) begin errors++; $display("FAIL bp_count got %0d want 16", got); end
    // A few extra cycles to catch a spurious trailing output.
    repeat (PS + 2) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_output tag %h", out_tag); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_mode = 2'b10; in_tag = TW'(i + 8); in_data = rand_block();
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_prefill out_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
    checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL rm_xfer_count got %h want 0", xfer_count); end
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rm_ghost_outputs got %0d want 0", seen); end
  endtask

  task automatic test_counter();
    int    fired = 0, cyc = 0;
    int    want;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b10;
    in_tag    = '0;
    in_data   = '0;
    while (fired < 65545 && cyc < 66000) begin
      @(negedge clk);
      #1;
      want = (fired > 65535) ? 65535 : fired;
      if ((fired % 4096) == 0 || fired >= 65533) begin
        checks++;
        if (xfer_count !== 16'(want)) begin
          errors++; $display("FAIL counter at %0d got %h want %h", fired, xfer_count, 16'(want));
        end
      end
      if (out_valid && out_ready) fired++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (fired < 65545) begin errors++; $display("FAIL counter_timeout got %0d want 65545", fired); end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    exp_q.delete();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
